i2s_master_xcvr: RTL

- I2S master transceiver for the WM8731 codec, sitting between the sample datapath and the codec pins in the top level.
- Generates i2s_bclk and i2s_lrclk from the 12.288 MHz system clock (mclk = clk, 256·fs).
- Serialises stereo 24-bit DAC samples onto i2s_dacdat and deserialises i2s_adcdat into stereo ADC samples.
- Philips I2S format: 32-bit slots, bclk = 64·fs = 3.072 MHz, lrclk = fs = 48 kHz.

---
 rtl/i2s_master_xcvr.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_master_xcvr.sv
// i2s_master_xcvr: Philips I2S master transceiver for the WM8731 codec.
// Derives bclk and lrclk from the 256*fs system clock. Serialises stereo DAC
// samples from a one-deep holding register. Deserialises the ADC stream into
// stereo sample pairs.
module i2s_master_xcvr #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tx_left,
   input  logic [DATA_WIDTH-1:0] tx_right,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_left,
   output logic [DATA_WIDTH-1:0] rx_right,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  i2s_bclk,
   output logic                  i2s_lrclk,
   output logic                  i2s_dacdat,
   input  logic                  i2s_adcdat
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

   localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_RISE_PRE = DIV_W'(BCLK_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] DIV_HALF     = DIV_W'(BCLK_DIV / 2);

   localparam logic [BIT_W-1:0] B_ONE      = BIT_W'(1);
   localparam logic [BIT_W-1:0] B_LAST     = BIT_W'(2 * SLOT_WIDTH - 1);
   localparam logic [BIT_W-1:0] B_LR_START = BIT_W'(SLOT_WIDTH - 1);
   localparam logic [BIT_W-1:0] B_LR_END   = BIT_W'(2 * SLOT_WIDTH - 2);
   localparam logic [BIT_W-1:0] B_L_END    = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] B_R_START  = BIT_W'(SLOT_WIDTH);
   localparam logic [BIT_W-1:0] B_R_END    = BIT_W'(SLOT_WIDTH + DATA_WIDTH - 1);

   logic [DIV_W-1:0]      div;
   logic [DIV_W-1:0]      div_next;
   logic [BIT_W-1:0]      b;
   logic [BIT_W-1:0]      b_next;
   logic                  fall_evt;
   logic                  rise_evt;
   logic                  frame_load;
   logic                  tx_handshake;
   logic                  tx_left_slot;
   logic                  tx_right_slot;
   logic                  rx_left_slot;
   logic                  rx_right_slot;

   logic                  hold_full;
   logic [DATA_WIDTH-1:0] hold_left;
   logic [DATA_WIDTH-1:0] hold_right;
   logic [DATA_WIDTH-1:0] load_left;
   logic [DATA_WIDTH-1:0] load_right;
   logic [DATA_WIDTH-1:0] frame_left;
   logic [DATA_WIDTH-1:0] frame_right;

   logic [DATA_WIDTH-1:0] rx_shift_left;
   logic [DATA_WIDTH-1:0] rx_shift_right;
   logic                  rx_done;

   assign tx_ready = ~hold_full;

   // Decode divider events, next counter values and slot membership of the bit index
   always_comb begin
      fall_evt = (div == DIV_LAST);
      rise_evt = (div == DIV_RISE_PRE);
      div_next = fall_evt ? '0 : div + DIV_ONE;
      b_next   = b;
      if (fall_evt) begin
         b_next = (b == B_LAST) ? '0 : b + B_ONE;
      end
      frame_load    = fall_evt && (b == B_LAST);
      tx_handshake  = tx_valid && !hold_full;
      load_left     = hold_full ? hold_left  : '0;
      load_right    = hold_full ? hold_right : '0;
      tx_left_slot  = (b_next <= B_L_END);
      tx_right_slot = (b_next >= B_R_START) && (b_next <= B_R_END);
      rx_left_slot  = (b <= B_L_END);
      rx_right_slot = (b >= B_R_START) && (b <= B_R_END);
   end

   // Divider, bit index and the two pin clocks advance together so edges stay aligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div       <= '0;
         b         <= B_LAST;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
      end else begin
         div      <= div_next;
         b        <= b_next;
         i2s_bclk <= (div_next >= DIV_HALF);
         if (fall_evt) begin
            i2s_lrclk <= (b_next >= B_LR_START) && (b_next <= B_LR_END);
         end
      end
   end

   // Holding register: a handshake fills it and the frame load empties it, with no bypass
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full   <= 1'b0;
         hold_left   <= '0;
         hold_right  <= '0;
         tx_underrun <= 1'b0;
      end else begin
         tx_underrun <= frame_load && !hold_full;
         if (frame_load) begin
            hold_full <= 1'b0;
         end
         if (tx_handshake) begin
            hold_full  <= 1'b1;
            hold_left  <= tx_left;
            hold_right <= tx_right;
         end
      end
   end

   // Serialiser: each falling event drives the bit for the new index, MSB first, zero padding
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_left  <= '0;
         frame_right <= '0;
         i2s_dacdat  <= 1'b0;
      end else if (fall_evt) begin
         if (frame_load) begin
            frame_left  <= {load_left[DATA_WIDTH-2:0], 1'b0};
            frame_right <= load_right;
            i2s_dacdat  <= load_left[DATA_WIDTH-1];
         end else if (tx_left_slot) begin
            frame_left <= {frame_left[DATA_WIDTH-2:0], 1'b0};
            i2s_dacdat <= frame_left[DATA_WIDTH-1];
         end else if (tx_right_slot) begin
            frame_right <= {frame_right[DATA_WIDTH-2:0], 1'b0};
            i2s_dacdat  <= frame_right[DATA_WIDTH-1];
         end else begin
            i2s_dacdat <= 1'b0;
         end
      end
   end

   // Deserialiser: shift in adcdat on rising events that fall inside a data bit position
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_shift_left  <= '0;
         rx_shift_right <= '0;
         rx_done        <= 1'b0;
      end else begin
         rx_done <= rise_evt && (b == B_R_END);
         if (rise_evt && rx_left_slot) begin
            rx_shift_left <= {rx_shift_left[DATA_WIDTH-2:0], i2s_adcdat};
         end
         if (rise_evt && rx_right_slot) begin
            rx_shift_right <= {rx_shift_right[DATA_WIDTH-2:0], i2s_adcdat};
         end
      end
   end

   // Publish the captured pair one clk after the last right bit has been sampled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_left  <= '0;
         rx_right <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= rx_done;
         if (rx_done) begin
            rx_left  <= rx_shift_left;
            rx_right <= rx_shift_right;
         end
      end
   end

endmodule
